// File: rtl/round_robin_arbiter_4_if.sv
// Request/grant bundle between requesters and the 4-way round-robin arbiter.
// The master side drives requests and release. The slave side (the arbiter) drives grants and status.
`timescale 1ns/1ps
interface round_robin_arbiter_4_if;
    logic [3:0] req_in;
    logic       release_in;
    logic [3:0] grant_out;
    logic [1:0] grant_id_out;
    logic       busy_out;
    logic       timeout_out;

    modport master (
        output req_in,
        output release_in,
        input  grant_out,
        input  grant_id_out,
        input  busy_out,
        input  timeout_out
    );

    modport slave (
        input  req_in,
        input  release_in,
        output grant_out,
        output grant_id_out,
        output busy_out,
        output timeout_out
    );
endinterface

// File: rtl/round_robin_arbiter_4.sv
// 4-requester round-robin arbiter with a bounded hold time and a one-cycle recovery gap.
// Every output comes straight from a register. The IDLE -> GRANT -> RECOVER sequence is a Moore FSM.
`timescale 1ns/1ps
module round_robin_arbiter_4 #(
    parameter int HOLD_MAX = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    round_robin_arbiter_4_if.slave  arb
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RECOVER = 2'd2
    } state_t;

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_MAX - 1);

    state_t     state_reg,    state_next;
    logic [3:0] grant_reg,    grant_next;
    logic [1:0] grant_id_reg, grant_id_next;
    logic [1:0] last_id_reg,  last_id_next;
    logic [3:0] hold_cnt_reg, hold_cnt_next;
    logic       timeout_reg,  timeout_next;
    logic       busy_reg,     busy_next;

    // Requests are rotated so that scan slot 0 is the requester right after the last winner.
    logic [1:0] scan_idx [4];
    logic [3:0] scan_req;

    for (genvar gi = 0; gi < 4; gi++) begin : g_scan
        assign scan_idx[gi] = last_id_reg + 2'(gi + 1);
        assign scan_req[gi] = arb.req_in[scan_idx[gi]];
    end

    logic       win_valid;
    logic [1:0] win_id;

    always_comb begin
        win_valid = 1'b0;
        win_id    = last_id_reg;
        for (int i = 3; i >= 0; i--) begin
            if (scan_req[i]) begin
                win_valid = 1'b1;
                win_id    = scan_idx[i];
            end
        end
    end

    logic holder_req;
    logic hold_done;
    logic early_exit;

    assign holder_req = arb.req_in[grant_id_reg];
    assign hold_done  = (hold_cnt_reg == HOLD_LAST);
    assign early_exit = arb.release_in | ~holder_req;

    always_comb begin
        state_next    = state_reg;
        grant_next    = grant_reg;
        grant_id_next = grant_id_reg;
        last_id_next  = last_id_reg;
        hold_cnt_next = hold_cnt_reg;
        timeout_next  = 1'b0;

        case (state_reg)
            IDLE: begin
                if (win_valid) begin
                    state_next    = GRANT;
                    grant_next    = 4'b0001 << win_id;
                    grant_id_next = win_id;
                    hold_cnt_next = 4'd0;
                end
            end
            GRANT: begin
                if (early_exit || hold_done) begin
                    state_next    = RECOVER;
                    grant_next    = 4'b0000;
                    last_id_next  = grant_id_reg;
                    hold_cnt_next = 4'd0;
                    // A release or request drop outranks the hold limit, even in the same cycle.
                    timeout_next  = ~early_exit;
                end else begin
                    hold_cnt_next = hold_cnt_reg + 4'd1;
                end
            end
            RECOVER: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                grant_next = 4'b0000;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg    <= IDLE;
            grant_reg    <= 4'b0000;
            grant_id_reg <= 2'd0;
            last_id_reg  <= 2'd3;
            hold_cnt_reg <= 4'd0;
            timeout_reg  <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            grant_reg    <= grant_next;
            grant_id_reg <= grant_id_next;
            last_id_reg  <= last_id_next;
            hold_cnt_reg <= hold_cnt_next;
            timeout_reg  <= timeout_next;
            busy_reg     <= busy_next;
        end
    end

    assign arb.grant_out    = grant_reg;
    assign arb.grant_id_out = grant_id_reg;
    assign arb.busy_out     = busy_reg;
    assign arb.timeout_out  = timeout_reg;

endmodule

// File: tb/tb_round_robin_arbiter_4.sv
// Scoreboard bench for round_robin_arbiter_4: directed grant sequences plus a random run checked by invariants.
// The stimulus side queues the expected grant transactions. The monitor rebuilds each grant from the outputs and compares it.
`timescale 1ns/1ps
module tb_round_robin_arbiter_4;

    localparam int HOLD_MAX = 8;

    logic clock;
    logic reset;

    round_robin_arbiter_4_if arb_if ();

    round_robin_arbiter_4 #(.HOLD_MAX(HOLD_MAX)) dut (
        .clock (clock),
        .reset (reset),
        .arb   (arb_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [1:0] id;
        int         len;
        logic       to;
        logic       busy;
    } txn_t;

    txn_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   sb_on = 1'b1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    task automatic expect_txn(input logic [1:0] id, input int len, input logic to, input logic busy);
        txn_t t;
        t.id   = id;
        t.len  = len;
        t.to   = to;
        t.busy = busy;
        exp_q.push_back(t);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            tick(1);
            k++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d grants still pending after %0d cycles, want 0", exp_q.size(), budget);
            exp_q.delete();
        end
    endtask

    task automatic chk_idle(input string tag);
        @(negedge clock);
        check({tag, ".grant"},   32'(arb_if.grant_out),    32'h0);
        check({tag, ".id"},      32'(arb_if.grant_id_out), 32'h0);
        check({tag, ".busy"},    32'(arb_if.busy_out),     32'h0);
        check({tag, ".timeout"}, 32'(arb_if.timeout_out),  32'h0);
    endtask

    task automatic do_reset();
        reset             = 1'b0;
        arb_if.req_in     = 4'b0000;
        arb_if.release_in = 1'b0;
        tick(2);
        reset = 1'b1;
    endtask

    // Monitor: rebuilds each grant (holder id, cycles held, timeout/busy in the cycle after) and checks the invariants.
    int         cur_len = 0;
    logic [1:0] cur_id  = 2'd0;
    int         wait_cnt [4] = '{0, 0, 0, 0};
    logic [3:0] req_prev = 4'b0000;

    always @(negedge clock) begin
        logic [3:0] g;
        txn_t       got;
        txn_t       want;
        g = arb_if.grant_out;
        check("onehot", 32'((g == 4'b0000) || (g == (4'b0001 << arb_if.grant_id_out))), 32'h1);

        if (g != 4'b0000) begin
            if (cur_len == 0) begin
                cur_id = arb_if.grant_id_out;
                for (int i = 0; i < 4; i++) begin
                    if (i == int'(cur_id)) begin
                        wait_cnt[i] = 0;
                    end else if (req_prev[i]) begin
                        wait_cnt[i]++;
                        check($sformatf("fair%0d", i), 32'(wait_cnt[i] <= 3), 32'h1);
                    end
                end
            end
            cur_len++;
        end else if (cur_len > 0) begin
            got.id   = cur_id;
            got.len  = cur_len;
            got.to   = arb_if.timeout_out;
            got.busy = arb_if.busy_out;
            check("hold_limit", 32'(cur_len <= HOLD_MAX), 32'h1);
            if (sb_on) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL grant: got id=%0d len=%0d to=%0b busy=%0b, want no grant",
                             got.id, got.len, got.to, got.busy);
                end else begin
                    want = exp_q.pop_front();
                    if (got.id !== want.id || got.len != want.len || got.to !== want.to || got.busy !== want.busy) begin
                        n_err++;
                        $display("FAIL grant: got id=%0d len=%0d to=%0b busy=%0b, want id=%0d len=%0d to=%0b busy=%0b",
                                 got.id, got.len, got.to, got.busy, want.id, want.len, want.to, want.busy);
                    end else begin
                        $display("grant id=%0d len=%0d to=%0b busy=%0b ok", got.id, got.len, got.to, got.busy);
                    end
                end
            end
            cur_len = 0;
        end

        for (int i = 0; i < 4; i++) begin
            if (!arb_if.req_in[i]) wait_cnt[i] = 0;
        end
        req_prev = arb_if.req_in;
    end

    initial begin
        reset             = 1'b0;
        arb_if.req_in     = 4'b0000;
        arb_if.release_in = 1'b0;
        tick(2);
        chk_idle("reset");

        // Requests asserted while reset is low must not reach the outputs.
        @(posedge clock); #1;
        arb_if.req_in = 4'b1111;
        tick(2);
        chk_idle("reset_hold");

        // All four requesting: full-length grants in rotation, each ended by the hold limit.
        @(posedge clock); #1;
        expect_txn(2'd0, 8, 1'b1, 1'b1);
        expect_txn(2'd1, 8, 1'b1, 1'b1);
        expect_txn(2'd2, 8, 1'b1, 1'b1);
        expect_txn(2'd3, 8, 1'b1, 1'b1);
        expect_txn(2'd0, 8, 1'b1, 1'b1);
        reset = 1'b1;
        wait_drain(80);
        arb_if.req_in = 4'b0000;
        tick(3);

        // Release on the third grant cycle, then the rotation continues from requester 2 to requester 3.
        do_reset();
        arb_if.req_in = 4'b0100;
        expect_txn(2'd2, 3, 1'b0, 1'b1);
        tick(3);
        arb_if.release_in = 1'b1;
        tick(1);
        arb_if.release_in = 1'b0;
        arb_if.req_in     = 4'b1010;
        expect_txn(2'd3, 8, 1'b1, 1'b1);
        wait_drain(40);
        arb_if.req_in = 4'b0000;
        tick(3);

        // The holder drops its request in its fourth grant cycle.
        do_reset();
        arb_if.req_in = 4'b0010;
        expect_txn(2'd1, 4, 1'b0, 1'b1);
        tick(4);
        arb_if.req_in = 4'b0000;
        wait_drain(20);
        tick(3);

        // Release arrives in the same cycle as the hold limit: no timeout flag.
        do_reset();
        arb_if.req_in = 4'b0001;
        expect_txn(2'd0, 8, 1'b0, 1'b1);
        tick(8);
        arb_if.release_in = 1'b1;
        tick(1);
        arb_if.release_in = 1'b0;
        arb_if.req_in     = 4'b0000;
        wait_drain(20);
        tick(3);

        // Reset in the second grant cycle: outputs clear, and requester 0 wins again afterwards.
        do_reset();
        arb_if.req_in = 4'b1001;
        expect_txn(2'd0, 2, 1'b0, 1'b0);
        tick(2);
        reset = 1'b0;
        tick(1);
        chk_idle("mid_grant_reset");
        @(posedge clock); #1;
        reset = 1'b1;
        expect_txn(2'd0, 8, 1'b1, 1'b1);
        expect_txn(2'd3, 8, 1'b1, 1'b1);
        wait_drain(60);
        arb_if.req_in = 4'b0000;
        tick(3);

        // Random run: only the one-hot, hold-limit and fairness invariants are checked here.
        sb_on = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            logic [3:0] r;
            r = arb_if.req_in;
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(15) == 0) r[b] = ~r[b];
            end
            arb_if.req_in     = r;
            arb_if.release_in = ($urandom_range(9) == 0);
            tick(1);
        end
        arb_if.req_in     = 4'b0000;
        arb_if.release_in = 1'b0;
        tick(HOLD_MAX + 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/round_robin_arbiter_4.md
ROUND_ROBIN_ARBITER_4 -- requirements
Module: round_robin_arbiter_4

Interface
REQ-001 The block SHALL have one parameter: HOLD_MAX, default 8, maximum consecutive cycles one grant may be held; legal range 2..15.
REQ-002 The block SHALL have the following ports:
- clock  input  1  sole clock; all state changes on rising edge.
- reset  input  1  synchronous, active-low reset.
- req_in  input  4  request lines; bit i = requester i.
- release_in  input  1  current grant holder finished; sampled only in GRANT.
- grant_out  output  4  one-hot grant to requester i; all-zero when no grant.
- grant_id_out  output  2  index of current grant, or of the most recent grant when none is active.
- busy_out  output  1  high whenever state is not IDLE.
- timeout_out  output  1  one-cycle flag: last grant ended by hold limit.
REQ-003 The design SHALL use one clock; reset SHALL be synchronous and active-low.
REQ-004 All outputs SHALL be driven from registers only (Moore style); no combinational path from any input to any output.

Function
REQ-005 The FSM SHALL have three states: IDLE, GRANT, RECOVER.
REQ-006 IDLE, req_in == 0: remain IDLE; grant_out = 0.
REQ-007 IDLE, req_in != 0 at edge k: select the first asserted requester scanning (last_id+1) mod 4 upward with wrap-around; after edge k, state = GRANT, grant_out one-hot for the winner, grant_id_out = winner, hold counter = 0.
REQ-008 GRANT: the hold counter (4 bits) SHALL increment by 1 on each edge that does not leave GRANT.
REQ-009 GRANT SHALL be exited to RECOVER on the first edge where any one of these holds:
- release_in = 1;
- req_in[grant_id_out] = 0;
- hold counter == HOLD_MAX-1 (timeout).
REQ-010 On the GRANT exit edge: grant_out -> 0, last_id <= grant_id_out, grant_id_out unchanged.
REQ-011 timeout_out SHALL be 1 during the RECOVER cycle only when the exit was caused by timeout alone; otherwise 0.
REQ-012 Exit priority: release_in or request drop takes precedence over timeout; simultaneous release and timeout -> timeout_out = 0.
REQ-013 RECOVER SHALL last exactly one cycle and always go to IDLE; req_in is ignored in RECOVER.
REQ-014 Grant length: a grant is held at most HOLD_MAX cycles; after any grant, grant_out is all-zero for at least 2 cycles (RECOVER, IDLE).
REQ-015 req_in changes on bits other than grant_id_out during GRANT SHALL have no effect.
REQ-016 grant_out SHALL never have more than one bit set.
REQ-017 Fairness: a continuously asserted requester SHALL be granted within 4 arbitration rounds.

Reset
REQ-018 With reset = 0 at a rising edge, after that edge: state = IDLE, grant_out = 0, grant_id_out = 0, busy_out = 0, timeout_out = 0, hold counter = 0, last_id = 3, so requester 0 has first priority.
REQ-019 Reset SHALL override all other inputs in any state, including mid-GRANT; grant_out drops to 0 on that edge.
REQ-020 Between reset edges (clock running, reset = 0), outputs SHALL hold their reset values.

Verification
REQ-021 Reset, then req_in = 4'b1111 held, release_in = 0, HOLD_MAX = 8 -> grants in order 0, 1, 2, 3, 0.
- Each grant is 8 cycles high.
- timeout_out = 1 in each RECOVER cycle.
- 2 zero-grant cycles between grants.
REQ-022 Reset, req_in = 4'b0100, release_in pulsed on the 3rd GRANT cycle -> grant_out = 4'b0100 for 3 cycles, grant_id_out = 2, timeout_out = 0; then req_in = 4'b1010 -> requester 3 granted next.
REQ-023 During a grant to requester 1, drop req_in[1] -> grant_out = 0 after the next edge, busy_out stays 1 for the RECOVER cycle, timeout_out = 0.
REQ-024 release_in = 1 on the same edge the hold counter reaches HOLD_MAX-1 -> RECOVER entered, timeout_out = 0.
REQ-025 Reset asserted on the 2nd cycle of a grant -> all outputs at reset values after that edge; first grant after reset goes to requester 0 when req_in = 4'b1001.
REQ-026 Across a randomized req_in/release_in run of at least 1000 cycles, a checker SHALL confirm:
- grant_out is one-hot or zero;
- no grant exceeds HOLD_MAX cycles;
- every requester held high continuously is served within 4 rounds.
